// File: rtl/font_glyph_serializer.sv
// Reads a 16x16 glyph from the font ROM one row at a time and streams its pixels with a valid/ready handshake.
// Optional FONT_SCALE2_EN: 2x pixel/row replication, 32x32 output.
module font_glyph_serializer #(
  parameter int unsigned GLYPH_ROWS = 16,
  parameter int unsigned GLYPH_COLS = 16,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [3:0]            Digit,
  output logic                  Busy,
  output logic [7:0]            RomAddress,
  input  logic [GLYPH_COLS-1:0] RomData,
  output logic                  PixelOut,
  output logic                  PixelValid,
  input  logic                  PixelReady,
  output logic [4:0]            PixelX,
  output logic [4:0]            PixelY,
  output logic                  Done
);

`ifdef FONT_SCALE2_EN
  localparam int unsigned SCALE_SH = 1;
`else
  localparam int unsigned SCALE_SH = 0;
`endif
  localparam int unsigned OUT_COLS = GLYPH_COLS << SCALE_SH;
  localparam int unsigned OUT_ROWS = GLYPH_ROWS << SCALE_SH;
  localparam logic [4:0]  LAST_COL = 5'(OUT_COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(OUT_ROWS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  state_t                state, state_nxt;
  logic [3:0]            digit_reg;
  logic [4:0]            row, col;
  logic [4:0]            row_nxt;
  logic [3:0]            rom_row_nxt;
  logic [GLYPH_COLS-1:0] shreg;
  logic [7:0]            rom_addr;
  logic                  last_col, last_row, src_advance;

  assign last_col    = (col == LAST_COL);
  assign last_row    = (row == LAST_ROW);
  assign row_nxt     = row + 5'd1;
  assign rom_row_nxt = 4'(row_nxt >> SCALE_SH);
  // With scaling each source bit is shown on two columns; only move on after the odd one.
  assign src_advance = (SCALE_SH == 0) || col[0];

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    Busy       = 1'b1;
    Done       = 1'b0;
    PixelValid = 1'b0;
    case (state)
      IDLE: begin
        Busy = 1'b0;
        if (Start) state_nxt = FETCH;
      end
      FETCH: state_nxt = SHIFT;
      SHIFT: begin
        PixelValid = 1'b1;
        if (PixelReady && last_col) state_nxt = last_row ? DONE : FETCH;
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      digit_reg <= '0;
      row       <= '0;
      col       <= '0;
      shreg     <= '0;
      rom_addr  <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          digit_reg <= Digit;
          row       <= '0;
          rom_addr  <= {Digit, 4'd0};
        end
        FETCH: begin
          shreg <= RomData;
          col   <= '0;
        end
        SHIFT: if (PixelReady) begin
          col <= last_col ? '0 : col + 5'd1;
          if (last_col) begin
            if (!last_row) begin
              row      <= row_nxt;
              rom_addr <= {digit_reg, rom_row_nxt};
            end
          end else if (src_advance) begin
            shreg <= MSB_FIRST ? {shreg[GLYPH_COLS-2:0], 1'b0}
                               : {1'b0, shreg[GLYPH_COLS-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign RomAddress = rom_addr;
  assign PixelX     = col;
  assign PixelY     = row;
  assign PixelOut   = PixelValid & (MSB_FIRST ? shreg[GLYPH_COLS-1] : shreg[0]);

endmodule
